// File: rtl/ber_measure_scheduler.sv
// ber_measure_scheduler
//   Runs bit-error-rate measurement windows over the audio (12-bit) and text
//   (8-bit) loopback streams, sharing one error-accumulation path. Each cycle
//   at most one stream is accepted. The accepted stream's differing bits are
//   counted and added to that channel's error total, and its word count
//   advances. The measurement ends once both channels have delivered
//   `window` words.
//
//   Build option: BER_SCHED_FIXED_PRIO_EN
//     defined   -> fixed priority, audio wins whenever both streams request
//     undefined -> round-robin between the two streams
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   start_i, window_i       start pulse (IDLE only) and words per channel
//   a_valid_i/a_ready_o     audio handshake; a_tx_i/a_rx_i the 12-bit word pair
//   t_valid_i/t_ready_o     text handshake;  t_tx_i/t_rx_i the 8-bit word pair
//   busy_o, done_o          busy while not IDLE; done is a 1-cycle end pulse
//   a/t_errors_o            saturating bit-error totals
//   a/t_words_o             words accepted per channel
//   a/t_sat_o               sticky saturation flags (cleared by start)
module ber_measure_scheduler #(
   parameter int CNT_W = 50,
   parameter int WIN_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIN_W-1:0] window_i,
   input  logic             a_valid_i,
   output logic             a_ready_o,
   input  logic [11:0]      a_tx_i,
   input  logic [11:0]      a_rx_i,
   input  logic             t_valid_i,
   output logic             t_ready_o,
   input  logic [7:0]       t_tx_i,
   input  logic [7:0]       t_rx_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] a_errors_o,
   output logic [CNT_W-1:0] t_errors_o,
   output logic [WIN_W-1:0] a_words_o,
   output logic [WIN_W-1:0] t_words_o,
   output logic             a_sat_o,
   output logic             t_sat_o
);

   localparam int SUM_W = CNT_W + 1;
   localparam logic [WIN_W-1:0] ONE_W = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIN_W-1:0] win_q;
   logic [CNT_W-1:0] a_err_q, t_err_q, a_err_d, t_err_d;
   logic [WIN_W-1:0] a_words_q, t_words_q, a_words_d, t_words_d;
   logic             a_sat_q, t_sat_q;
   logic             busy_q, done_q;
`ifndef BER_SCHED_FIXED_PRIO_EN
   logic             last_t_q;   // 1: text was the most recent grant
`endif

   function automatic logic [3:0] popcnt12(input logic [11:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 12; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   // ---------------- arbitration ----------------
   logic a_req, t_req, a_gnt, t_gnt, a_xfer, t_xfer;

   // A channel stops requesting once it has its full window of words.
   assign a_req = (state_q == S_RUN) && a_valid_i && (a_words_q < win_q);
   assign t_req = (state_q == S_RUN) && t_valid_i && (t_words_q < win_q);

`ifdef BER_SCHED_FIXED_PRIO_EN
   assign a_gnt = a_req;
   assign t_gnt = t_req && !a_req;
`else
   // On contention the stream not granted most recently wins.
   assign a_gnt = a_req && (!t_req ||  last_t_q);
   assign t_gnt = t_req && (!a_req || !last_t_q);
`endif

   assign a_ready_o = a_gnt;
   assign t_ready_o = t_gnt;
   assign a_xfer    = a_gnt;   // grant implies valid
   assign t_xfer    = t_gnt;

   // ---------------- accumulation ----------------
   logic [SUM_W-1:0] a_sum, t_sum;

   assign a_sum = {1'b0, a_err_q} + SUM_W'(popcnt12(a_tx_i ^ a_rx_i));
   assign t_sum = {1'b0, t_err_q} + SUM_W'(popcnt12({4'h0, t_tx_i ^ t_rx_i}));

   // Carry out of the accumulator width means overflow: clamp to all-ones.
   assign a_err_d   = a_sum[CNT_W] ? '1 : a_sum[CNT_W-1:0];
   assign t_err_d   = t_sum[CNT_W] ? '1 : t_sum[CNT_W-1:0];
   assign a_words_d = a_xfer ? a_words_q + ONE_W : a_words_q;
   assign t_words_d = t_xfer ? t_words_q + ONE_W : t_words_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         win_q     <= '0;
         a_err_q   <= '0;
         t_err_q   <= '0;
         a_words_q <= '0;
         t_words_q <= '0;
         a_sat_q   <= 1'b0;
         t_sat_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifndef BER_SCHED_FIXED_PRIO_EN
         last_t_q  <= 1'b1;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  win_q     <= window_i;
                  a_err_q   <= '0;
                  t_err_q   <= '0;
                  a_words_q <= '0;
                  t_words_q <= '0;
                  a_sat_q   <= 1'b0;
                  t_sat_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  if (window_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (a_xfer) begin
                  a_err_q   <= a_err_d;
                  a_sat_q   <= a_sat_q | a_sum[CNT_W];
                  a_words_q <= a_words_d;
               end
               if (t_xfer) begin
                  t_err_q   <= t_err_d;
                  t_sat_q   <= t_sat_q | t_sum[CNT_W];
                  t_words_q <= t_words_d;
               end
`ifndef BER_SCHED_FIXED_PRIO_EN
               if (a_xfer || t_xfer) last_t_q <= t_xfer;
`endif
               // Finish on the same edge as the final transfer.
               if ((a_words_d == win_q) && (t_words_d == win_q)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign a_errors_o = a_err_q;
   assign t_errors_o = t_err_q;
   assign a_words_o  = a_words_q;
   assign t_words_o  = t_words_q;
   assign a_sat_o    = a_sat_q;
   assign t_sat_o    = t_sat_q;

endmodule

// File: tb/tb_ber_measure_scheduler.sv
// Bench for ber_measure_scheduler: two instances share one stimulus stream,
// one at the default 50-bit accumulator width and one at 4 bits so that
// saturation is reached. A cycle-level reference model built from the
// measurement rules predicts every output each cycle.
module tb_ber_measure_scheduler;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] window = '0;
   logic        a_valid = 1'b0, t_valid = 1'b0;
   logic [11:0] a_tx = '0, a_rx = '0;
   logic [7:0]  t_tx = '0, t_rx = '0;

   logic        a_ready, t_ready, busy, done, a_sat, t_sat;
   logic [49:0] a_err, t_err;
   logic [15:0] a_w, t_w;
   logic        s_a_ready, s_t_ready, s_busy, s_done, s_a_sat, s_t_sat;
   logic [3:0]  s_a_err, s_t_err;
   logic [15:0] s_a_w, s_t_w;

   ber_measure_scheduler u_dut (
      .clock(clock), .reset(reset), .start_i(start), .window_i(window),
      .a_valid_i(a_valid), .a_ready_o(a_ready), .a_tx_i(a_tx), .a_rx_i(a_rx),
      .t_valid_i(t_valid), .t_ready_o(t_ready), .t_tx_i(t_tx), .t_rx_i(t_rx),
      .busy_o(busy), .done_o(done), .a_errors_o(a_err), .t_errors_o(t_err),
      .a_words_o(a_w), .t_words_o(t_w), .a_sat_o(a_sat), .t_sat_o(t_sat));

   ber_measure_scheduler #(.CNT_W(4)) u_sat (
      .clock(clock), .reset(reset), .start_i(start), .window_i(window),
      .a_valid_i(a_valid), .a_ready_o(s_a_ready), .a_tx_i(a_tx), .a_rx_i(a_rx),
      .t_valid_i(t_valid), .t_ready_o(s_t_ready), .t_tx_i(t_tx), .t_rx_i(t_rx),
      .busy_o(s_busy), .done_o(s_done), .a_errors_o(s_a_err), .t_errors_o(s_t_err),
      .a_words_o(s_a_w), .t_words_o(s_t_w), .a_sat_o(s_a_sat), .t_sat_o(s_t_sat));

   always #5 clock = ~clock;

   int n_vec = 0, n_err = 0;

   // reference model state
   int      m_state;            // 0 idle, 1 run, 2 done
   int      m_win, m_aw, m_tw;
   longint  m_ae, m_te, m_ae4, m_te4;
   bit      m_as, m_ts, m_as4, m_ts4;
   bit      m_last_t;           // text granted most recently
   bit      ea, et;             // expected readies this cycle
   logic [7:0] seq;             // grant history, 2'b01 = A, 2'b10 = T
   int      n_done, n_rdy;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sadd(input longint acc, input int pc, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (acc + pc > mx) ? mx : acc + pc;
   endfunction

   function automatic bit ovf(input longint acc, input int pc, input int w);
      return (acc + pc) > ((longint'(1) << w) - 1);
   endfunction

   task automatic model_reset();
      m_state = 0; m_win = 0; m_aw = 0; m_tw = 0;
      m_ae = 0; m_te = 0; m_ae4 = 0; m_te4 = 0;
      m_as = 0; m_ts = 0; m_as4 = 0; m_ts4 = 0;
      m_last_t = 1; ea = 0; et = 0;
   endtask

   task automatic chk_all();
      chk("a_ready", a_ready, ea);
      chk("t_ready", t_ready, et);
      chk("s_a_ready", s_a_ready, ea);
      chk("s_t_ready", s_t_ready, et);
      chk("busy", busy, m_state != 0);
      chk("done", done, m_state == 2);
      chk("s_done", s_done, m_state == 2);
      chk("a_errors", a_err, m_ae);
      chk("t_errors", t_err, m_te);
      chk("a_words", a_w, m_aw);
      chk("t_words", t_w, m_tw);
      chk("a_sat", a_sat, m_as);
      chk("t_sat", t_sat, m_ts);
      chk("s_a_errors", s_a_err, m_ae4);
      chk("s_t_errors", s_t_err, m_te4);
      chk("s_a_sat", s_a_sat, m_as4);
      chk("s_t_sat", s_t_sat, m_ts4);
   endtask

   // One clock: called at posedge+1 with inputs already driven.
   task automatic cyc();
      bit ra, rt;
      int pa, pt;
      @(negedge clock);
      ea = 0; et = 0;
      if (m_state == 1) begin
         ra = a_valid && (m_aw < m_win);
         rt = t_valid && (m_tw < m_win);
`ifdef BER_SCHED_FIXED_PRIO_EN
         ea = ra; et = rt && !ra;
`else
         if (ra && rt) begin ea = m_last_t; et = !m_last_t; end
         else begin ea = ra; et = rt; end
`endif
      end
      chk_all();
      if (a_ready && a_valid) seq = {seq[5:0], 2'b01};
      if (t_ready && t_valid) seq = {seq[5:0], 2'b10};
      if (done) n_done++;
      if (a_ready || t_ready) n_rdy++;
      @(posedge clock);
      pa = $countones(a_tx ^ a_rx);
      pt = $countones(t_tx ^ t_rx);
      case (m_state)
         0: if (start) begin
               m_aw = 0; m_tw = 0; m_ae = 0; m_te = 0; m_ae4 = 0; m_te4 = 0;
               m_as = 0; m_ts = 0; m_as4 = 0; m_ts4 = 0;
               m_win = int'(window);
               m_state = (window == 0) ? 2 : 1;
            end
         1: begin
               if (ea) begin
                  m_as  |= ovf(m_ae, pa, 50);  m_ae  = sadd(m_ae, pa, 50);
                  m_as4 |= ovf(m_ae4, pa, 4);  m_ae4 = sadd(m_ae4, pa, 4);
                  m_aw++; m_last_t = 0;
               end
               if (et) begin
                  m_ts  |= ovf(m_te, pt, 50);  m_te  = sadd(m_te, pt, 50);
                  m_ts4 |= ovf(m_te4, pt, 4);  m_te4 = sadd(m_te4, pt, 4);
                  m_tw++; m_last_t = 1;
               end
               if (m_aw == m_win && m_tw == m_win) m_state = 2;
            end
         default: m_state = 0;
      endcase
      #1;
   endtask

   // Called at posedge+1; asynchronous reset pulse between clock edges.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      chk_all();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      @(posedge clock); #1;
      do_reset();

      // alternating grants
      window = 2; a_valid = 1; t_valid = 1;
      a_tx = 12'hFFF; a_rx = 12'h000; t_tx = 8'h0F; t_rx = 8'h00;
      seq = '0; n_done = 0;
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 6; i++) cyc();
`ifdef BER_SCHED_FIXED_PRIO_EN
      chk("grant_seq", seq, 8'b01_01_10_10);
`else
      chk("grant_seq", seq, 8'b01_10_01_10);
`endif
      chk("alt_a_errors", a_err, 24);
      chk("alt_t_errors", t_err, 8);
      chk("alt_a_words", a_w, 2);
      chk("alt_t_words", t_w, 2);
      chk("alt_done_cnt", n_done, 1);

      // empty window
      window = 0; n_rdy = 0; n_done = 0;
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 3; i++) cyc();
      chk("empty_rdy", n_rdy, 0);
      chk("empty_done_cnt", n_done, 1);

      // saturation on the narrow instance
      window = 2; a_tx = 12'hFFF; a_rx = 12'h000; t_tx = 8'h5A; t_rx = 8'h5A;
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 6; i++) cyc();
      chk("sat_a_err", s_a_err, 15);
      chk("sat_flag", s_a_sat, 1);
      chk("sat_t_err", s_t_err, 0);
      window = 1;
      start = 1; cyc(); start = 0;
      chk("sat_clr", s_a_sat, 0);
      for (int i = 0; i < 4; i++) cyc();

      // one-sided stall
      window = 3; a_valid = 1; t_valid = 0; n_done = 0;
      start = 1; cyc(); start = 0;
      for (int i = 0; i < 6; i++) cyc();
      chk("stall_a_words", a_w, 3);
      chk("stall_busy", busy, 1);
      chk("stall_a_ready", a_ready, 0);
      chk("stall_no_done", n_done, 0);
      t_valid = 1;
      for (int i = 0; i < 5; i++) cyc();
      chk("stall_done_cnt", n_done, 1);

      // ignored start in RUN, then reset mid-measurement
      window = 4; a_valid = 1; t_valid = 1;
      start = 1; cyc(); start = 0;
      cyc();
      window = 1; start = 1; cyc(); start = 0;
      chk("ign_words", a_w + t_w, 2);
      do_reset();
      chk("rst_busy", busy, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 7) == 0);
         window  = 16'($urandom_range(0, 5));
         a_valid = ($urandom_range(0, 3) != 0);
         t_valid = ($urandom_range(0, 3) != 0);
         a_tx = 12'($urandom); a_rx = 12'($urandom);
         t_tx = 8'($urandom);  t_rx = 8'($urandom);
         if ($urandom_range(0, 399) == 0) do_reset();
         else cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
